// File: rtl/asteroid_fall_ctrl.sv
// Falling-asteroid controller paced by the frame tick: spawn, fall, collide or dodge, score.
// Optional ASTEROID_SPEEDUP_EN shortens the fall period every SPEEDUP_EVERY dodges.
module asteroid_fall_ctrl #(
    parameter int X_W           = 4,
    parameter int Y_W           = 6,
    parameter int Y_LAST        = 47,
    parameter int SHIP_ROW      = 44,
    parameter int FALL_DIV      = 4,
    parameter int SCORE_W       = 8,
    parameter int SPEEDUP_EVERY = 8
) (
    input  logic               cin,
    input  logic               resetn,
    input  logic               tick,
    input  logic               start,
    input  logic [X_W-1:0]     ship_x,
    output logic [X_W-1:0]     ast_x,
    output logic [Y_W-1:0]     ast_y,
    output logic               ast_active,
    output logic               hit,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    // state   | meaning
    // S_IDLE  | waiting for first start, asteroid hidden
    // S_SPAWN | one cycle: place asteroid at row 0, random column
    // S_FALL  | count ticks, step one row per period
    // S_OVER  | collision happened, asteroid frozen until restart

    localparam int CNT_W = $clog2(FALL_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_FALL, S_OVER} state_t;

    generate
        if (FALL_DIV < 1 || SPEEDUP_EVERY < 1 || X_W > 8 || SHIP_ROW >= Y_LAST)
            $error("asteroid_fall_ctrl: illegal parameter combination");
    endgenerate

    state_t             state_q;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   tick_cnt_q;
    logic [CNT_W-1:0]   period_w;
    logic [X_W-1:0]     ast_x_q;
    logic [Y_W-1:0]     ast_y_q;
    logic               ast_active_q, hit_q, game_over_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               step_w;

`ifdef ASTEROID_SPEEDUP_EN
    logic [CNT_W-1:0]   period_q;
    logic               speedup_w;
    assign period_w  = period_q;
    assign speedup_w = (score_q != '1) && ((32'(score_d) % SPEEDUP_EVERY) == 0);
`else
    assign period_w  = CNT_W'(FALL_DIV);
`endif

    // x^8+x^6+x^5+x^4+1; a nonzero seed keeps it out of the all-zero lockup
    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign score_d = (score_q == '1) ? score_q : score_q + 1'b1;
    assign step_w  = tick && (tick_cnt_q == period_w - 1'b1);

    always_ff @(posedge cin or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            lfsr_q       <= 8'hA5;
            tick_cnt_q   <= '0;
            ast_x_q      <= '0;
            ast_y_q      <= '0;
            ast_active_q <= 1'b0;
            hit_q        <= 1'b0;
            game_over_q  <= 1'b0;
            score_q      <= '0;
`ifdef ASTEROID_SPEEDUP_EN
            period_q     <= CNT_W'(FALL_DIV);
`endif
        end else begin
            lfsr_q <= lfsr_d;
            hit_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_SPAWN;
                end
                S_SPAWN: begin
                    ast_x_q      <= lfsr_q[X_W-1:0];
                    ast_y_q      <= '0;
                    ast_active_q <= 1'b1;
                    tick_cnt_q   <= '0;
                    state_q      <= S_FALL;
                end
                S_FALL: begin
                    if (step_w) begin
                        tick_cnt_q <= '0;
                        if (ast_y_q == Y_W'(SHIP_ROW) && ast_x_q == ship_x) begin
                            hit_q       <= 1'b1;
                            game_over_q <= 1'b1;
                            state_q     <= S_OVER;
                        end else if (ast_y_q == Y_W'(Y_LAST)) begin
                            score_q      <= score_d;
                            ast_active_q <= 1'b0;
                            state_q      <= S_SPAWN;
`ifdef ASTEROID_SPEEDUP_EN
                            if (speedup_w && period_q > CNT_W'(1))
                                period_q <= period_q - 1'b1;
`endif
                        end else begin
                            ast_y_q <= ast_y_q + 1'b1;
                        end
                    end else if (tick) begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        score_q     <= '0;
                        game_over_q <= 1'b0;
                        state_q     <= S_SPAWN;
`ifdef ASTEROID_SPEEDUP_EN
                        period_q    <= CNT_W'(FALL_DIV);
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ast_x      = ast_x_q;
    assign ast_y      = ast_y_q;
    assign ast_active = ast_active_q;
    assign hit        = hit_q;
    assign game_over  = game_over_q;
    assign score      = score_q;

endmodule
